// File: rtl/rx_packet_ctrl.sv
// rtl/rx_packet_ctrl.sv - sync/length/payload/check frame parser staging verified packets in a FIFO.
// Optional inter-byte timeout with receiver reset pulse is enabled by defining RX_TIMEOUT_EN.
module rx_packet_ctrl #(
  parameter int         DEPTH   = 16,
  parameter int         MAXLEN  = 16,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 400
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rxdata,
  input  logic       rxfinish,
  output logic       rxreset,
  output logic [7:0] pkt_data,
  output logic       pkt_last,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DROP
  } state_t;

  state_t        state_q, state_d;
  logic          rxfinish_q;
  logic [PW-1:0] wr_tent_q, wr_tent_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    xor_q, xor_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          rxreset_q, rxreset_d;

  logic [8:0]    mem [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [8:0]    wdata;
  logic [8:0]    head;

  logic          byte_stb;
  logic          pop;
  logic [PW-1:0] occ;
  logic [15:0]   free_w;

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout;
`endif

  assign byte_stb  = rxfinish & ~rxfinish_q;
  assign occ       = wr_tent_q - rd_q;
  assign free_w    = 16'(DEPTH) - 16'(occ);
  assign pkt_valid = (rd_q != wr_commit_q);
  assign pop       = pkt_valid & pkt_ready;
  assign head      = mem[rd_q[AW-1:0]];
  // Outputs are gated so an empty FIFO presents zeros, including right after reset.
  assign pkt_data  = pkt_valid ? head[7:0] : 8'd0;
  assign pkt_last  = pkt_valid ? head[8] : 1'b0;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign rxreset   = rxreset_q;

`ifdef RX_TIMEOUT_EN
  always_comb begin
    tmo_d   = tmo_q;
    timeout = 1'b0;
    if (byte_stb || state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
      timeout = 1'b1;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    wr_tent_d   = wr_tent_q;
    wr_commit_d = wr_commit_q;
    rd_d        = pop ? rd_q + PW'(1) : rd_q;
    cnt_d       = cnt_q;
    xor_d       = xor_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    rxreset_d   = 1'b0;
    we          = 1'b0;
    waddr       = wr_tent_q[AW-1:0];
    wdata       = {(cnt_q == 8'd1), rxdata};
    if (byte_stb) begin
      case (state_q)
        S_IDLE: begin
          if (rxdata == SYNC) state_d = S_LEN;
        end
        S_LEN: begin
          if (rxdata == 8'd0 || int'(rxdata) > MAXLEN) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
            state_d    = S_IDLE;
          end else if (free_w < 16'(rxdata)) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
            cnt_d      = rxdata + 8'd1;
            state_d    = S_DROP;
          end else begin
            xor_d   = rxdata;
            cnt_d   = rxdata;
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          we        = 1'b1;
          wr_tent_d = wr_tent_q + PW'(1);
          xor_d     = xor_q ^ rxdata;
          cnt_d     = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_CHECK;
        end
        S_CHECK: begin
          if (rxdata == xor_q) begin
            wr_commit_d = wr_tent_q;
          end else begin
            wr_tent_d  = wr_commit_q;
            err_d      = 1'b1;
            err_code_d = 2'd0;
          end
          state_d = S_IDLE;
        end
        S_DROP: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef RX_TIMEOUT_EN
    else if (timeout) begin
      wr_tent_d  = wr_commit_q;
      err_d      = 1'b1;
      err_code_d = 2'd3;
      rxreset_d  = 1'b1;
      state_d    = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rxfinish_q  <= 1'b0;
      wr_tent_q   <= '0;
      wr_commit_q <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      xor_q       <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      rxreset_q   <= 1'b0;
`ifdef RX_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rxfinish_q  <= rxfinish;
      wr_tent_q   <= wr_tent_d;
      wr_commit_q <= wr_commit_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      xor_q       <= xor_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      rxreset_q   <= rxreset_d;
`ifdef RX_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// tb/tb_rx_packet_ctrl.sv - scoreboard bench for rx_packet_ctrl (RX_TIMEOUT_EN aware).
module tb_rx_packet_ctrl;

  typedef logic [7:0] bq_t[$];

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rxdata;
  logic       rxfinish;
  logic       rxreset;
  logic [7:0] pkt_data;
  logic       pkt_last;
  logic       pkt_valid;
  logic       pkt_ready;
  logic       err;
  logic [1:0] err_code;

  int total = 0;
  int bad = 0;
  int rx_pulses = 0;
  logic rxreset_prev = 1'b0;
  logic [8:0] exp_q[$];
  logic [1:0] err_exp[$];

  rx_packet_ctrl dut (
    .clock(clock), .reset(reset), .rxdata(rxdata), .rxfinish(rxfinish),
    .rxreset(rxreset), .pkt_data(pkt_data), .pkt_last(pkt_last),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .err(err), .err_code(err_code)
  );

  always #5 clock = ~clock;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) check("unexpected_pkt", {23'd0, pkt_last, pkt_data}, 0);
        else check("pkt_byte", {23'd0, pkt_last, pkt_data}, {23'd0, exp_q.pop_front()});
      end
      if (err) begin
        if (err_exp.size() == 0) check("unexpected_err", {30'd0, err_code}, 4);
        else check("err_code", {30'd0, err_code}, {30'd0, err_exp.pop_front()});
      end
      if (rxreset) rx_pulses++;
      if (rxreset && rxreset_prev) check("rxreset_width", 2, 1);
      rxreset_prev = rxreset;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    rxdata   = b;
    rxfinish = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    rxfinish = 1'b0;
  endtask

  task automatic send_good(input bq_t p);
    logic [7:0] chk;
    chk = 8'(p.size());
    send_byte(8'hA5);
    send_byte(8'(p.size()));
    foreach (p[i]) begin
      exp_q.push_back({(i == p.size() - 1), p[i]});
      chk = chk ^ p[i];
      send_byte(p[i]);
    end
    send_byte(chk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || err_exp.size() != 0) && n < 2000) begin
      @(posedge clock);
      n++;
    end
    repeat (3) @(posedge clock);
    check("drain_in_time", (n < 2000) ? 1 : 0, 1);
  endtask

  initial begin
    bq_t q;
    reset = 1'b1; rxfinish = 1'b0; rxdata = 8'h00; pkt_ready = 1'b1;
    @(negedge clock);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_pkt_data", pkt_data, 0);
    check("rst_pkt_last", pkt_last, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_rxreset", rxreset, 0);
    @(posedge clock); #1 reset = 1'b0;

    // Good frame with hand-computed check byte 03
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    foreach (q[i]) q.delete();
    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    foreach (q[i]) send_byte(q[i]);
    wait_drain();

    // Bad check byte: nothing delivered, checksum error, then a good frame
    err_exp.push_back(2'd0);
    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    foreach (q[i]) send_byte(q[i]);
    wait_drain();
    q = '{8'hAA, 8'hBB};
    send_good(q);
    wait_drain();

    // Stray bytes, zero and oversize lengths
    err_exp.push_back(2'd1);
    err_exp.push_back(2'd1);
    q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h11};
    foreach (q[i]) send_byte(q[i]);
    wait_drain();
    check("err_code_held", err_code, 1);

    // Stalled consumer: fill 16 entries, third frame has no room and is skipped
    pkt_ready = 1'b0;
    q.delete();
    for (int i = 1; i <= 8; i++) q.push_back(8'(i));
    send_good(q);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'(8'h10 + i));
    send_good(q);
    err_exp.push_back(2'd2);
    q = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    foreach (q[i]) send_byte(q[i]);
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("full_valid", pkt_valid, 1);
    check("full_exp_left", exp_q.size(), 16);
    @(posedge clock); #1 pkt_ready = 1'b1;
    wait_drain();
    q = '{8'hC3, 8'h3C, 8'h5A, 8'hA5};
    send_good(q);
    wait_drain();

    // Inter-byte silence mid-frame
    q = '{8'hA5, 8'h03, 8'h11};
`ifdef RX_TIMEOUT_EN
    err_exp.push_back(2'd3);
    foreach (q[i]) send_byte(q[i]);
    repeat (450) @(posedge clock);
    check("timeout_pulses", rx_pulses, 1);
    wait_drain();
`else
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    foreach (q[i]) send_byte(q[i]);
    repeat (450) @(posedge clock);
    check("no_timeout_pulse", rx_pulses, 0);
    q = '{8'h22, 8'h33, 8'h03};
    foreach (q[i]) send_byte(q[i]);
    wait_drain();
`endif

    // Reset mid-frame empties FIFO including committed data
    pkt_ready = 1'b0;
    q = '{8'h55};
    send_good(q);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("pre_reset_valid", pkt_valid, 1);
    q = '{8'hA5, 8'h03, 8'h11};
    foreach (q[i]) send_byte(q[i]);
    @(posedge clock); #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check("midrst_pkt_valid", pkt_valid, 0);
    check("midrst_pkt_data", pkt_data, 0);
    check("midrst_err", err, 0);
    @(posedge clock); #1 reset = 1'b0; pkt_ready = 1'b1;
    @(negedge clock);
    check("post_rst_valid", pkt_valid, 0);
    q = '{8'h01, 8'h80, 8'h7E};
    send_good(q);
    wait_drain();

    check("exp_left", exp_q.size(), 0);
    check("err_left", err_exp.size(), 0);
`ifdef RX_TIMEOUT_EN
    check("final_pulses", rx_pulses, 1);
`else
    check("final_pulses", rx_pulses, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
